// File: rtl/sim_exit_ctrl_if.sv
// sim_exit_ctrl_if: OBI slave port bundle for sim_exit_ctrl.
interface sim_exit_ctrl_if;
  logic        req_i, we_i, gnt_o, rvalid_o;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  modport master (output req_i, we_i, be_i, addr_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
  modport slave (input req_i, we_i, be_i, addr_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/sim_exit_ctrl.sv
// sim_exit_ctrl: OBI exit-code/cycle-counter peripheral; SIM_EXIT_WATCHDOG_EN adds a watchdog on WDOG_LIMIT.
module sim_exit_ctrl #(
  parameter logic [31:0] WDOG_RESET_LIMIT = 32'd0,
  parameter logic [31:0] WDOG_EXIT_CODE   = 32'h0000_0DEAD
) (
  input  logic           clk,
  input  logic           rst_n,
  sim_exit_ctrl_if.slave bus,
  output logic           exit_valid_o,
  output logic [31:0]    exit_value_o
);
  typedef enum logic {RUN, DONE} state_e;
  state_e      state, state_nxt;
  logic [31:0] exit_val, cyc_cnt, exit_code, wdog_limit, rdata_sel, rdata_q;
  logic [1:0]  offs;
  logic        rvalid_q, wr, sw_trig, wdog_exp, unused_addr;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
  assign offs        = bus.addr_i[3:2];
  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};
  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  // Register writes only take effect while running; DONE freezes everything.
  assign wr      = bus.req_i && bus.we_i && state == RUN;
  assign sw_trig = wr && offs == 2'd1 && bus.be_i[0] && bus.wdata_i[0];
`ifdef SIM_EXIT_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog_limit <= WDOG_RESET_LIMIT;
    else if (wr && offs == 2'd3) wdog_limit <= be_merge(wdog_limit, bus.wdata_i, bus.be_i);
  assign wdog_exp = state == RUN && wdog_limit != '0 && cyc_cnt >= wdog_limit;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_RESET_LIMIT;
  assign wdog_limit  = '0;
  assign wdog_exp    = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nxt;
  always_comb state_nxt = (state == RUN && (sw_trig || wdog_exp)) ? DONE : state;
  always_comb begin
    exit_valid_o = state == DONE;
    exit_value_o = state == DONE ? exit_code : '0;
  end
  assign rdata_sel = offs == 2'd0 ? exit_val :
                     offs == 2'd1 ? {31'd0, exit_valid_o} :
                     offs == 2'd2 ? cyc_cnt : wdog_limit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exit_val  <= '0;
      cyc_cnt   <= '0;
      exit_code <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= bus.req_i;
      rdata_q  <= (bus.req_i && !bus.we_i) ? rdata_sel : '0;
      if (wr && offs == 2'd0) exit_val <= be_merge(exit_val, bus.wdata_i, bus.be_i);
      // The counter stops on the cycle the exit is taken, so it reports the exit cycle.
      if (state_nxt == RUN && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      if (state == RUN && state_nxt == DONE) exit_code <= sw_trig ? exit_val : WDOG_EXIT_CODE;
    end
endmodule

// File: tb/tb_sim_exit_ctrl.sv
// tb_sim_exit_ctrl: randomized + directed scoreboard bench for sim_exit_ctrl.
module tb_sim_exit_ctrl;
`ifdef SIM_EXIT_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam logic [31:0] DEAD = 32'h0000_0DEAD;
  logic clk = 1'b0, rst_n = 1'b0;
  logic exit_valid_o;
  logic [31:0] exit_value_o;
  sim_exit_ctrl_if bus();
  sim_exit_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_val, m_cnt, m_lim, m_code;
  bit m_done;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_val = 0; m_cnt = 0; m_lim = 0; m_code = 0; m_done = 0;
  endtask
  // Reference model: advance by one clock edge using the currently driven request.
  task automatic step();
    logic [31:0] mask;
    logic [1:0] a;
    bit w, trig, expire;
    a = bus.addr_i[3:2];
    mask = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
    if (bus.req_i)
      exp_q.push_back(bus.we_i ? 32'd0 : a == 0 ? m_val : a == 1 ? {31'd0, m_done} : a == 2 ? m_cnt : m_lim);
    w = bus.req_i && bus.we_i && !m_done;
    trig = w && a == 1 && bus.be_i[0] && bus.wdata_i[0];
    expire = WDOG && !m_done && m_lim != 0 && m_cnt >= m_lim;
    if (trig || expire) begin
      m_done = 1;
      m_code = trig ? m_val : DEAD;
    end else if (!m_done && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (w && a == 0) m_val = (m_val & ~mask) | (bus.wdata_i & mask);
    if (WDOG && w && a == 3) m_lim = (m_lim & ~mask) | (bus.wdata_i & mask);
  endtask
  task automatic tick(input bit req, input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_i = req; bus.we_i = we; bus.be_i = be; bus.addr_i = addr; bus.wdata_i = wd;
    step();
    #1 chk("gnt", {31'd0, bus.gnt_o}, {31'd0, req});
  endtask
  task automatic idle(input int n);
    repeat (n) tick(0, 0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    tick(1, 1, be, {28'h0, a, 2'b00}, d);
  endtask
  task automatic rd_reg(input logic [1:0] a);
    tick(1, 0, 4'hF, {28'h0, a, 2'b00}, 32'h0);
  endtask
  // Reset lands just after an edge, killing the response of the transfer accepted there.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 0;
    model_reset();
    exp_q.delete();
    #1 chk("rst_exit_valid", {31'd0, exit_valid_o}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
    @(negedge clk);
    bus.req_i = 0; bus.we_i = 0;
    @(negedge clk);
    rst_n = 1;
    step();
  endtask
  always @(posedge clk) begin
    #2;
    chk("exit_valid", {31'd0, exit_valid_o}, {31'd0, m_done});
    chk("exit_value", exit_value_o, m_done ? m_code : 32'd0);
    chk("rvalid", {31'd0, bus.rvalid_o}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("rdata", bus.rdata_o, exp_q.pop_front());
    else chk("rdata_idle", bus.rdata_o, 32'd0);
  end
  initial begin
    logic [31:0] r, d;
    logic [1:0] a;
    int kind;
    bus.req_i = 0; bus.we_i = 0; bus.be_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 3));
      r = $urandom;
      d = $urandom;
      a = 2'($urandom_range(0, 3));
      if (a == 1) d[0] = 1'b0;
      tick(kind != 0, kind >= 2, 4'($urandom), {r[31:4], a, r[1:0]}, d);
    end
    do_reset();
    idle(19);
    rd_reg(2);
    @(posedge clk);
    #2 chk("cnt_at_20", bus.rdata_o, 32'd20);
    rd_reg(0);
    @(posedge clk);
    #2 chk("b2b_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    chk("b2b_exit_val", bus.rdata_o, 32'd0);
    wr_reg(1, 32'hFFFF_FFFE);
    wr_reg(1, 32'h1, 4'b1110);
    wr_reg(0, 32'h1234_5678, 4'b0011);
    wr_reg(1, 32'h1);
    @(posedge clk);
    #2 chk("trig_valid", {31'd0, exit_valid_o}, 32'd1);
    chk("trig_value", exit_value_o, 32'h0000_5678);
    wr_reg(0, 32'hFFFF_FFFF);
    rd_reg(0);
    @(posedge clk);
    #2 chk("done_wr_ignored", bus.rdata_o, 32'h0000_5678);
    rd_reg(2); rd_reg(2); rd_reg(1);
    idle(20);
    chk("sticky_value", exit_value_o, 32'h0000_5678);
    do_reset();
    idle(4);
    rd_reg(2);
    @(posedge clk);
    #2 chk("cnt_resume", bus.rdata_o, 32'd5);
    wr_reg(0, 32'h0);
    wr_reg(1, 32'h1);
    idle(100);
    chk("zero_exit_valid", {31'd0, exit_valid_o}, 32'd1);
    chk("zero_exit_value", exit_value_o, 32'd0);
    do_reset();
    if (WDOG) begin
      wr_reg(3, 32'd50);
      for (int i = 0; i < 200 && !exit_valid_o; i++) idle(1);
      chk("wdog_valid", {31'd0, exit_valid_o}, 32'd1);
      chk("wdog_value", exit_value_o, DEAD);
      rd_reg(2);
      @(posedge clk);
      #2 chk("wdog_cnt", bus.rdata_o, 32'd50);
      do_reset();
      wr_reg(0, 32'd7);
      wr_reg(3, 32'd60);
      while (m_cnt < 60) idle(1);
      wr_reg(1, 32'h1);
      @(posedge clk);
      #2 chk("race_value", exit_value_o, 32'd7);
      wr_reg(0, 32'd99);
      idle(2);
      chk("race_hold", exit_value_o, 32'd7);
    end else begin
      wr_reg(3, 32'd50);
      rd_reg(3);
      @(posedge clk);
      #2 chk("wdog_reg_zero", bus.rdata_o, 32'd0);
      idle(60);
      chk("no_wdog", {31'd0, exit_valid_o}, 32'd0);
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sim_exit_ctrl.md
SIM_EXIT_CTRL -- requirements
Module: sim_exit_ctrl

Interface
REQ-001 Parameter WDOG_RESET_LIMIT, 32'd0, reset value of WDOG_LIMIT; 0 = watchdog off.
REQ-002 Parameter WDOG_EXIT_CODE, 32'h0000_0DEAD, exit value reported on watchdog expiry.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  OBI request.
REQ-006 we_i  input  1  write enable, 1 = write.
REQ-007 be_i  input  4  byte enables.
REQ-008 addr_i  input  32  byte address; only bits [3:2] decoded.
REQ-009 wdata_i  input  32  write data.
REQ-010 gnt_o  output  1  grant.
REQ-011 rvalid_o  output  1  response valid.
REQ-012 rdata_o  output  32  read data.
REQ-013 exit_valid_o  output  1  simulation finished, consumed by the testbench top.
REQ-014 exit_value_o  output  32  exit code; 0 = success.

Function
REQ-015 Register map (word offset = addr_i[3:2]): 0 EXIT_VALUE RW; 1 EXIT_CTRL (bit0 exit trigger W, reads exit_valid_o); 2 CYCLE_CNT RO; 3 WDOG_LIMIT RW.
REQ-016 gnt_o SHALL equal req_i combinationally; a transfer is accepted in any cycle with req_i=1.
REQ-017 rvalid_o SHALL be 1 exactly one cycle after every accepted transfer, reads and writes alike, back-to-back supported.
REQ-018 rdata_o SHALL carry the addressed register value sampled at acceptance in the rvalid_o cycle; 0 otherwise and on write responses.
REQ-019 Writes to EXIT_VALUE and WDOG_LIMIT SHALL update only bytes with be_i set.
REQ-020 FSM states RUN, DONE; reset state RUN.
REQ-021 RUN->DONE on accepted write to EXIT_CTRL with be_i[0]=1 and wdata_i[0]=1; exit_valid_o=1 from the next cycle and exit_value_o = EXIT_VALUE including any same-cycle effect (none possible; one transfer per cycle).
REQ-022 RUN->DONE on watchdog expiry (REQ-030); exit_value_o = WDOG_EXIT_CODE.
REQ-023 Software trigger and watchdog expiry in the same cycle: software trigger wins, exit_value_o = EXIT_VALUE.
REQ-024 DONE is sticky until reset; exit_valid_o and exit_value_o SHALL hold constant; writes in DONE accepted and responded to but have no effect.
REQ-025 Writing EXIT_CTRL bit0=0 SHALL have no effect.
REQ-026 CYCLE_CNT increments by 1 each cycle in RUN, saturates at 32'hFFFF_FFFF, freezes in DONE.
REQ-027 exit_value_o SHALL read 0 while in RUN.

Reset
REQ-028 On rst_n=0 asynchronously: state RUN, EXIT_VALUE=0, CYCLE_CNT=0, WDOG_LIMIT=WDOG_RESET_LIMIT, exit_valid_o=0, exit_value_o=0, rvalid_o=0, rdata_o=0.
REQ-029 Reset asserted mid-transfer SHALL drop the pending response; no rvalid_o after release for it.

Configuration
REQ-030 Macro SIM_EXIT_WATCHDOG_EN defined: in RUN, WDOG_LIMIT!=0 and CYCLE_CNT>=WDOG_LIMIT triggers expiry in that cycle.
REQ-031 Macro undefined: no watchdog logic; offset 3 reads 0, writes ignored, REQ-022 never occurs.

Verification
REQ-032 Write EXIT_VALUE=0, then EXIT_CTRL=1 -> exit_valid_o=1 one cycle after second grant, exit_value_o=0, stays high 100 cycles.
REQ-033 Write EXIT_VALUE=32'h12345678 with be_i=4'b0011, then trigger -> exit_value_o=32'h00005678.
REQ-034 Read CYCLE_CNT at reset release +20 cycles, back-to-back with read of EXIT_VALUE -> rvalid_o high two consecutive cycles, counter value 20 (+/-0 per bench alignment), then EXIT_VALUE.
REQ-035 SIM_EXIT_WATCHDOG_EN, WDOG_LIMIT=50, no trigger -> exit_valid_o=1, exit_value_o=32'h0000_0DEAD, CYCLE_CNT frozen at 50.
REQ-036 Trigger in same cycle CYCLE_CNT reaches WDOG_LIMIT with EXIT_VALUE=7 -> exit_value_o=7; subsequent EXIT_VALUE write leaves exit_value_o=7.
REQ-037 Assert rst_n in DONE -> exit_valid_o=0, CYCLE_CNT=0 immediately, counting resumes after release.
